// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_mem_sequencer: strided, masked vector load/store over a req/ack port.   |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module vec_mem_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ELEMS    = 16,
    parameter int ADDR_W   = 16,
    parameter int STRIDE_W = 8,
    parameter int CNT_W    = $clog2(ELEMS)
) (
    input  logic                    Clk1,
    input  logic                    Reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_store,
    input  logic [ADDR_W-1:0]       cmd_base,
    input  logic [STRIDE_W-1:0]     cmd_stride,
    input  logic [CNT_W-1:0]        cmd_count,
    input  logic [ELEMS-1:0]        cmd_mask,
    input  logic [ELEMS*DATA_W-1:0] st_vec,
    output logic [ELEMS*DATA_W-1:0] ld_vec,
    output logic                    done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX_IDX = CNT_W'(ELEMS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [STRIDE_W-1:0]     stride_q, stride_d;
    logic                    store_q, store_d;
    logic [ELEMS-1:0]        mask_q, mask_d;
    logic [ELEMS*DATA_W-1:0] snap_q, snap_d;
    logic [ELEMS*DATA_W-1:0] ld_vec_q, ld_vec_d;

    logic                    w_lane_en;
    logic                    w_advance;
    logic [ADDR_W-1:0]       w_stride_ext;

    assign w_lane_en    = mask_q[idx_q];
    assign w_stride_ext = {{(ADDR_W-STRIDE_W){stride_q[STRIDE_W-1]}}, stride_q};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        store_d   = store_q;
        mask_d    = mask_q;
        snap_d    = snap_q;
        ld_vec_d  = ld_vec_q;
        w_advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    store_d  = cmd_store;
                    addr_d   = cmd_base;
                    stride_d = cmd_stride;
                    count_d  = (cmd_count > C_MAX_IDX) ? C_MAX_IDX : cmd_count;
                    mask_d   = cmd_mask;
                    snap_d   = st_vec;
                    idx_d    = '0;
                    if (!cmd_store) begin
                        ld_vec_d = '0;
                    end
                    state_d  = XFER;
                end
            end
            XFER: begin
                // A disabled lane costs one cycle; an enabled one waits for its ack.
                w_advance = !w_lane_en || mem_ack;
                if (w_lane_en && mem_ack && !store_q) begin
                    ld_vec_d[int'(idx_q)*DATA_W +: DATA_W] = mem_rdata;
                end
                if (w_advance) begin
                    if (idx_q == count_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        addr_d = addr_q + w_stride_ext;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            store_q  <= 1'b0;
            mask_q   <= '0;
            snap_q   <= '0;
            ld_vec_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            store_q  <= store_d;
            mask_q   <= mask_d;
            snap_q   <= snap_d;
            ld_vec_q <= ld_vec_d;
        end
    end

    // Outputs decode flops only, so they hold steady through memory wait states.
    assign cmd_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign mem_req   = (state_q == XFER) && w_lane_en;
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = (mem_req && store_q) ? snap_q[int'(idx_q)*DATA_W +: DATA_W] : '0;
    assign ld_vec    = ld_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vec_mem_sequencer: randomized bench with a wait-state memory responder.  |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module tb_vec_mem_sequencer;

    localparam int DATA_W   = 16;
    localparam int ELEMS    = 16;
    localparam int ADDR_W   = 16;
    localparam int STRIDE_W = 8;
    localparam int CNT_W    = 4;

    logic                    Clk1;
    logic                    Reset;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_store;
    logic [ADDR_W-1:0]       cmd_base;
    logic [STRIDE_W-1:0]     cmd_stride;
    logic [CNT_W-1:0]        cmd_count;
    logic [ELEMS-1:0]        cmd_mask;
    logic [ELEMS*DATA_W-1:0] st_vec;
    logic [ELEMS*DATA_W-1:0] ld_vec;
    logic                    done;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ack;
    logic [DATA_W-1:0]       mem_rdata;

    vec_mem_sequencer #(
        .DATA_W  (DATA_W),
        .ELEMS   (ELEMS),
        .ADDR_W  (ADDR_W),
        .STRIDE_W(STRIDE_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_store (cmd_store),
        .cmd_base  (cmd_base),
        .cmd_stride(cmd_stride),
        .cmd_count (cmd_count),
        .cmd_mask  (cmd_mask),
        .st_vec    (st_vec),
        .ld_vec    (ld_vec),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          wait_cfg = 0;
    bit          noise_en = 0;
    int          unstable = 0;
    int          wcnt     = 0;
    logic [32:0] held;
    logic [32:0] acc_log[$];
    logic [ELEMS*DATA_W-1:0] model_ld = '0;

    initial begin
        Clk1 = 1'b0;
        forever #5 Clk1 = ~Clk1;
    end

    function automatic logic [15:0] rd(input logic [15:0] a);
        return 16'(a * 3);
    endfunction

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks each request after wait_cfg extra cycles and logs the beat.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge Clk1);
            if (!Reset) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req) begin
                if (wcnt == 0) held = {mem_we, mem_addr, mem_wdata};
                else if ({mem_we, mem_addr, mem_wdata} !== held) unstable++;
                if (wcnt >= wait_cfg) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd(mem_addr);
                    acc_log.push_back({mem_we, mem_addr, mem_wdata});
                    wcnt      = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt      = 0;
                mem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    task automatic run_cmd(input logic st_op, input logic [15:0] base, input logic [7:0] stride,
                           input logic [3:0] count, input logic [15:0] mask,
                           input logic [255:0] stv, input int waits, input bit poke,
                           input string tag);
        logic [32:0]  exp_log[$];
        logic [255:0] new_ld;
        int           nen;
        int           a;
        int           k;
        int           exp_k;
        bit           busy_ready;
        nen    = 0;
        new_ld = '0;
        for (int i = 0; i <= int'(count); i++) begin
            if (mask[i]) begin
                a = int'(base) + i * int'($signed(stride));
                exp_log.push_back({st_op, 16'(a), st_op ? stv[i*16 +: 16] : 16'h0000});
                if (!st_op) new_ld[i*16 +: 16] = rd(16'(a));
                nen++;
            end
        end
        exp_k = (int'(count) + 1) + waits * nen + 1;

        wait_cfg = waits;
        unstable = 0;
        @(negedge Clk1);
        acc_log.delete();
        check_val({tag, "_ready_idle"}, cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_store  = st_op;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_count  = count;
        cmd_mask   = mask;
        st_vec     = stv;
        @(negedge Clk1);
        cmd_valid = 1'b0;
        cmd_base  = 16'($urandom);
        st_vec    = {8{$urandom}};
        k          = 1;
        busy_ready = 1'b0;
        while (!done && k < 1000) begin
            if (cmd_ready) busy_ready = 1'b1;
            if (poke && k == 3) begin
                cmd_valid  = 1'b1;
                cmd_store  = ~st_op;
                cmd_base   = 16'h5555;
                cmd_count  = 4'd0;
                cmd_mask   = '1;
                st_vec     = {8{$urandom}};
            end
            if (poke && k == 4) cmd_valid = 1'b0;
            @(negedge Clk1);
            k++;
        end
        check_val({tag, "_latency"}, k, exp_k);
        check_val({tag, "_ready_busy"}, busy_ready, 0);
        check_val({tag, "_ready_in_done"}, cmd_ready, 0);
        check_val({tag, "_stable"}, unstable, 0);
        check_val({tag, "_nreq"}, acc_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < acc_log.size(); i++) begin
            check_val($sformatf("%s_beat%0d", tag, i), acc_log[i], exp_log[i]);
        end
        if (!st_op) model_ld = new_ld;
        check_val({tag, "_ld_vec"}, ld_vec, model_ld);
        @(negedge Clk1);
        check_val({tag, "_done_width"}, done, 0);
        check_val({tag, "_ready_after"}, cmd_ready, 1);
    endtask

    initial begin
        logic [255:0] stv;
        int           k;
        bit           done_seen;
        Reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_store  = 1'b0;
        cmd_base   = '0;
        cmd_stride = '0;
        cmd_count  = '0;
        cmd_mask   = '0;
        st_vec     = '0;
        repeat (3) @(negedge Clk1);
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_outs", {done, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check_val("rst_ld_vec", ld_vec, 0);
        Reset = 1'b1;

        // Full-length unit-stride load
        run_cmd(1'b0, 16'h0010, 8'h01, 4'd15, 16'hFFFF, '0, 0, 1'b0, "t1");
        // Negative stride store with address wrap; ld_vec must keep the last load
        stv = '0;
        for (int i = 0; i < 4; i++) stv[i*16 +: 16] = 16'hA000 + 16'(i);
        run_cmd(1'b1, 16'h0001, 8'hFE, 4'd3, 16'hFFFF, stv, 0, 1'b0, "t2");
        // Sparse-mask load
        run_cmd(1'b0, 16'h0100, 8'h01, 4'd7, 16'h00A5, '0, 0, 1'b0, "t3");
        // Store with three wait states per request
        run_cmd(1'b1, 16'h2000, 8'h04, 4'd5, 16'hFFFF, {8{$urandom}}, 3, 1'b0, "t4");
        // Busy store poked with a competing command and changing st_vec
        run_cmd(1'b1, 16'h3000, 8'h00, 4'd9, 16'hFFFF, {8{$urandom}}, 1, 1'b1, "t6");

        // Reset in the middle of a store
        wait_cfg = 0;
        @(negedge Clk1);
        cmd_valid = 1'b1;
        cmd_store = 1'b1;
        cmd_base  = 16'h4000;
        cmd_stride = 8'h01;
        cmd_count = 4'd15;
        cmd_mask  = 16'hFFFF;
        st_vec    = {8{$urandom}};
        @(negedge Clk1);
        cmd_valid = 1'b0;
        acc_log.delete();
        k = 0;
        while (acc_log.size() < 2 && k < 100) begin
            @(negedge Clk1);
            #1;
            k++;
        end
        check_val("t5_two_acks", acc_log.size() >= 2, 1);
        Reset = 1'b0;
        @(negedge Clk1);
        model_ld = '0;
        check_val("t5_req_low", mem_req, 0);
        check_val("t5_ld_cleared", ld_vec, model_ld);
        check_val("t5_ready", cmd_ready, 1);
        Reset = 1'b1;
        done_seen = 1'b0;
        repeat (20) begin
            @(negedge Clk1);
            if (done) done_seen = 1'b1;
        end
        check_val("t5_no_done", done_seen, 0);
        run_cmd(1'b0, 16'h0700, 8'h03, 4'd4, 16'h001F, '0, 0, 1'b0, "t5_load");

        // Randomized commands, with stray acks while no request is pending
        noise_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            logic       r_st;
            logic [3:0] r_cnt;
            r_st  = 1'($urandom_range(0, 1));
            r_cnt = 4'($urandom);
            run_cmd(r_st, 16'($urandom), 8'($urandom), r_cnt, 16'($urandom),
                    {8{$urandom}}, $urandom_range(0, 2), (r_cnt >= 4'd6),
                    $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
